sprite_memory_arbiter: RTL and testbench

//  Shares the single-port sprite memory between two requesters on clk_100:
//   - pixel-fetch reads from the print module (real-time, absolute priority);
//   - sprite write instructions from the decoder path, buffered in a small FIFO.

---
 rtl/sprite_memory_arbiter.sv | 127 ++++++++++++
 tb/tb_sprite_memory_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_memory_arbiter.sv
// Single-port sprite memory arbiter: pixel reads have absolute priority,
// sprite writes are buffered in a small FIFO and drain on read-free cycles.
module sprite_memory_arbiter #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DATA_W       = 9,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_req,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    input  logic                        wr_valid,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    output logic                        wr_done,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_q,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        starved
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t                 state, state_next;
    logic [ADDR_W-1:0]      fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       starve_cnt, starve_cnt_next;
    logic [MEM_LATENCY-1:0] rd_pipe, rd_pipe_next;
    logic                   push, pop;
    logic [ADDR_W-1:0]      mem_addr_next;
    logic [DATA_W-1:0]      mem_data_next, rd_data_next;
    logic                   mem_wren_next, rd_valid_next;
    logic [LVL_W-1:0]       level_next;

    // Grant decision and next values for every registered output
    always_comb begin
        state_next      = S_IDLE;
        push            = wr_valid && wr_ready;
        pop             = 1'b0;
        mem_addr_next   = mem_addr;
        mem_data_next   = mem_data;
        mem_wren_next   = 1'b0;
        starve_cnt_next = '0;
        rd_pipe_next    = (rd_pipe << 1) | MEM_LATENCY'(state == S_RD);
        rd_valid_next   = rd_pipe[MEM_LATENCY-1];
        rd_data_next    = rd_pipe[MEM_LATENCY-1] ? mem_q : rd_data;

        if (rd_req) begin
            state_next = S_RD;
        end else if (fifo_level != '0) begin
            state_next = S_WR;
        end

        case (state_next)
            S_RD: mem_addr_next = rd_addr;
            S_WR: begin
                pop           = 1'b1;
                mem_addr_next = fifo_addr[rd_ptr];
                mem_data_next = fifo_data[rd_ptr];
                mem_wren_next = 1'b1;
            end
            default: ;
        endcase

        level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);

        // Only a read blocking a non-empty FIFO advances the counter; pops and empty clear it
        if (rd_req && fifo_level != '0) begin
            starve_cnt_next = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt
                                                                   : starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            rd_pipe    <= '0;
            fifo_level <= '0;
            wr_ready   <= 1'b1;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_wren   <= 1'b0;
            wr_done    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            starved    <= 1'b0;
        end else begin
            state      <= state_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            starve_cnt <= starve_cnt_next;
            rd_pipe    <= rd_pipe_next;
            fifo_level <= level_next;
            wr_ready   <= (level_next != LVL_W'(FIFO_DEPTH));
            mem_addr   <= mem_addr_next;
            mem_data   <= mem_data_next;
            mem_wren   <= mem_wren_next;
            wr_done    <= mem_wren_next;
            rd_valid   <= rd_valid_next;
            rd_data    <= rd_data_next;
            starved    <= (starve_cnt_next == CNT_W'(STARVE_LIMIT));
        end
    end

    // FIFO storage needs no reset; pointers and level define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sprite_memory_arbiter.sv
// Bench for sprite_memory_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the arbitration rules.
`timescale 1ns/1ps
module tb_sprite_memory_arbiter;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 9;
    localparam int unsigned LVL_W     = 3;
    localparam int unsigned MEM_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready, wr_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    logic [LVL_W-1:0]  fifo_level;
    logic              starved;

    int n_cmp = 0;
    int n_bad = 0;

    sprite_memory_arbiter dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_done(wr_done),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
        .fifo_level(fifo_level), .starved(starved)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_default(input logic [ADDR_W-1:0] a);
        return (a == 14'h0123) ? 9'h0F0 : DATA_W'(32'(a) * 37 + 5);
    endfunction

    // Sprite memory: one-edge registered read, read-before-write
    logic [DATA_W-1:0] tb_mem [MEM_WORDS];
    bit                tb_wr  [MEM_WORDS];
    always @(posedge clk) begin
        if (mem_wren) begin
            tb_mem[mem_addr] <= mem_data;
            tb_wr[mem_addr]  <= 1'b1;
        end
        mem_q <= tb_wr[mem_addr] ? tb_mem[mem_addr] : mem_default(mem_addr);
    end

    // Reference model state
    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
    typedef struct { int due; logic [DATA_W-1:0] d; } rd_t;
    wr_t               mq[$];
    rd_t               rq[$];
    logic [DATA_W-1:0] sh_mem [MEM_WORDS];
    bit                sh_wr  [MEM_WORDS];
    bit                pend_v, m_ready;
    wr_t               pend;
    int                starve, cyc = 0, exp_level;
    logic              exp_wren, exp_done, exp_rvalid, exp_starved, exp_ready;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data, exp_rdata;

    task model_reset();
        mq.delete(); rq.delete();
        pend_v = 0; m_ready = 1; starve = 0; exp_level = 0;
        exp_wren = 0; exp_done = 0; exp_rvalid = 0; exp_starved = 0; exp_ready = 1;
        exp_addr = '0; exp_data = '0; exp_rdata = '0;
    endtask

    // Predicts outputs after the coming edge from the inputs currently applied
    task model_step();
        wr_t e;
        rd_t r;
        bit  push;
        cyc++;
        push = wr_valid && m_ready;
        if (pend_v) begin
            sh_mem[pend.a] = pend.d; sh_wr[pend.a] = 1; pend_v = 0;
        end
        exp_wren = 0; exp_done = 0; exp_rvalid = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front(); exp_rvalid = 1; exp_rdata = r.d;
        end
        if (rd_req) begin
            exp_addr = rd_addr;
            rq.push_back('{cyc + 2, sh_wr[rd_addr] ? sh_mem[rd_addr] : mem_default(rd_addr)});
            starve = (mq.size() == 0) ? 0 : ((starve < 255) ? starve + 1 : 255);
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_addr = e.a; exp_data = e.d; exp_wren = 1; exp_done = 1;
            pend = e; pend_v = 1; starve = 0;
        end else begin
            starve = 0;
        end
        if (push) mq.push_back('{wr_addr, wr_data});
        m_ready = mq.size() < 4;
        exp_ready = m_ready; exp_level = mq.size(); exp_starved = (starve == 255);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rd_req = 1; rd_addr = 14'h0010; wr_valid = 1; wr_addr = 14'h0200; wr_data = 9'h011;
        tick(); tick(); wr_valid = 0; tick();
        n_cmp++; if (fifo_level !== 3'd2) begin n_bad++; $display("FAIL pre_reset_level: got %0d want 2", fifo_level); end
        #2 reset = 1; model_reset(); #1;
        n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        n_cmp++; if ({starved, wr_done, mem_addr, mem_data, rd_data} !== '0) begin
            n_bad++; $display("FAIL reset_others: starved=%b done=%b addr=%h data=%h rdata=%h want all 0",
                              starved, wr_done, mem_addr, mem_data, rd_data);
        end
        rd_req = 0;
        @(posedge clk); #3 reset = 0;
        tick();
        n_cmp++; if (mem_wren !== 1'b0 || fifo_level !== 3'd0) begin
            n_bad++; $display("FAIL reset_discard: wren=%b level=%0d want 0/0", mem_wren, fifo_level);
        end
    endtask

    task automatic test_single_write();
        wr_valid = 1; wr_addr = 14'h0050; wr_data = 9'h1A5;
        tick(); wr_valid = 0;
        n_cmp++; if (fifo_level !== 3'd1 || mem_wren !== 1'b0) begin
            n_bad++; $display("FAIL single_push: level=%0d wren=%b want 1/0", fifo_level, mem_wren);
        end
        tick();
        n_cmp++; if ({mem_wren, wr_done, mem_addr, mem_data, fifo_level} !== {1'b1, 1'b1, 14'h0050, 9'h1A5, 3'd0}) begin
            n_bad++; $display("FAIL single_commit: wren=%b done=%b addr=%h data=%h level=%0d want 1/1/0050/1a5/0",
                              mem_wren, wr_done, mem_addr, mem_data, fifo_level);
        end
        tick();
        n_cmp++; if (mem_wren !== 1'b0 || wr_done !== 1'b0) begin
            n_bad++; $display("FAIL single_pulse: wren=%b done=%b want 0/0", mem_wren, wr_done);
        end
    endtask

    task automatic test_fill_drain();
        logic [DATA_W-1:0] d [4];
        rd_req = 1; rd_addr = 14'h0300;
        for (int i = 0; i < 4; i++) begin
            d[i] = DATA_W'($urandom);
            wr_valid = 1; wr_addr = ADDR_W'(14'h0210 + i); wr_data = d[i];
            tick();
            n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("FAIL fill_no_write[%0d]: got %b want 0", i, mem_wren); end
        end
        n_cmp++; if (fifo_level !== 3'd4 || wr_ready !== 1'b0) begin
            n_bad++; $display("FAIL fill_full: level=%0d ready=%b want 4/0", fifo_level, wr_ready);
        end
        // Push offered while full in a popping cycle must be refused
        rd_req = 0; wr_addr = 14'h0233; wr_data = 9'h1FF;
        for (int i = 0; i < 4; i++) begin
            tick(); wr_valid = 0;
            n_cmp++; if ({mem_wren, mem_addr, mem_data, fifo_level} !== {1'b1, ADDR_W'(14'h0210 + i), d[i], LVL_W'(3 - i)}) begin
                n_bad++; $display("FAIL drain[%0d]: wren=%b addr=%h data=%h level=%0d want 1/%h/%h/%0d",
                                  i, mem_wren, mem_addr, mem_data, fifo_level, 14'h0210 + i, d[i], 3 - i);
            end
        end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready: got %b want 1", wr_ready); end
        tick();
        n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("FAIL drain_extra_write: got %b want 0", mem_wren); end
    endtask

    task automatic test_read_latency();
        int nvalid = 0, runs = 0;
        logic prev = 1'b0;
        rd_req = 1; rd_addr = 14'h0123;
        tick(); rd_req = 0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_lat_k: got %b want 0", rd_valid); end
        tick();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_lat_k1: got %b want 0", rd_valid); end
        tick();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 9'h0F0) begin
            n_bad++; $display("FAIL rd_lat_k2: valid=%b data=%h want 1/0f0", rd_valid, rd_data);
        end
        tick();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_lat_k3: got %b want 0", rd_valid); end
        for (int i = 0; i < 644; i++) begin
            rd_req = (i < 640); rd_addr = ADDR_W'($urandom);
            tick();
            if (rd_valid) begin nvalid++; if (!prev) runs++; end
            prev = rd_valid;
            n_cmp++; if (rd_valid !== exp_rvalid) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, rd_valid, exp_rvalid); end
            if (exp_rvalid) begin
                n_cmp++; if (rd_data !== exp_rdata) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rd_data, exp_rdata); end
            end
        end
        n_cmp++; if (nvalid != 640 || runs != 1) begin
            n_bad++; $display("FAIL b2b_contiguous: valid=%0d runs=%0d want 640/1", nvalid, runs);
        end
    endtask

    task automatic test_starvation();
        rd_req = 1; rd_addr = 14'h0400; wr_valid = 1; wr_addr = 14'h0220; wr_data = 9'h0AA;
        tick(); wr_valid = 0;
        n_cmp++; if (fifo_level !== 3'd1 || starved !== 1'b0) begin
            n_bad++; $display("FAIL starve_setup: level=%0d starved=%b want 1/0", fifo_level, starved);
        end
        for (int n = 1; n <= 300; n++) begin
            tick();
            n_cmp++; if (starved !== (n >= 255)) begin n_bad++; $display("FAIL starve_flag[%0d]: got %b want %b", n, starved, n >= 255); end
        end
        rd_req = 0;
        tick();
        n_cmp++; if ({mem_wren, mem_addr, mem_data, starved} !== {1'b1, 14'h0220, 9'h0AA, 1'b0}) begin
            n_bad++; $display("FAIL starve_release: wren=%b addr=%h data=%h starved=%b want 1/0220/0aa/0",
                              mem_wren, mem_addr, mem_data, starved);
        end
    endtask

    task automatic test_reset_drain();
        rd_req = 1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_addr = ADDR_W'(14'h0228 + i); wr_data = DATA_W'($urandom);
            tick();
        end
        wr_valid = 0; rd_req = 0;
        tick();
        n_cmp++; if (mem_wren !== 1'b1 || fifo_level !== 3'd3) begin
            n_bad++; $display("FAIL rdrain_setup: wren=%b level=%0d want 1/3", mem_wren, fifo_level);
        end
        #2 reset = 1; model_reset(); #1;
        n_cmp++; if (mem_wren !== 1'b0 || fifo_level !== 3'd0) begin
            n_bad++; $display("FAIL rdrain_reset: wren=%b level=%0d want 0/0", mem_wren, fifo_level);
        end
        @(posedge clk); #3 reset = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (mem_wren !== 1'b0 || fifo_level !== 3'd0) begin
                n_bad++; $display("FAIL rdrain_after[%0d]: wren=%b level=%0d want 0/0", i, mem_wren, fifo_level);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rd_req   = ($urandom_range(0, 99) < (((i / 50) % 2) ? 90 : 40));
            rd_addr  = ADDR_W'(14'h0200 + $urandom_range(0, 63));
            wr_valid = $urandom_range(0, 1) == 1;
            wr_addr  = ADDR_W'(14'h0200 + $urandom_range(0, 63));
            wr_data  = DATA_W'($urandom);
            tick();
            n_cmp++; if ({mem_wren, wr_done, mem_addr, fifo_level, wr_ready, starved, rd_valid} !==
                         {exp_wren, exp_done, exp_addr, LVL_W'(exp_level), exp_ready, exp_starved, exp_rvalid}) begin
                n_bad++; $display("FAIL rand_ctl[%0d]: wren=%b done=%b addr=%h lvl=%0d rdy=%b stv=%b rv=%b want %b/%b/%h/%0d/%b/%b/%b",
                                  i, mem_wren, wr_done, mem_addr, fifo_level, wr_ready, starved, rd_valid,
                                  exp_wren, exp_done, exp_addr, exp_level, exp_ready, exp_starved, exp_rvalid);
            end
            if (exp_wren) begin
                n_cmp++; if (mem_data !== exp_data) begin n_bad++; $display("FAIL rand_wdata[%0d]: got %h want %h", i, mem_data, exp_data); end
            end
            if (exp_rvalid) begin
                n_cmp++; if (rd_data !== exp_rdata) begin n_bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, rd_data, exp_rdata); end
            end
        end
        rd_req = 0; wr_valid = 0;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++; if (fifo_level !== 3'd0 || mem_wren !== 1'b0) begin
            n_bad++; $display("FAIL rand_settle: level=%0d wren=%b want 0/0", fifo_level, mem_wren);
        end
    endtask

    initial begin
        model_reset();
        #2 reset = 1;
        #20 reset = 0;
        test_reset();
        test_single_write();
        test_fill_drain();
        test_read_latency();
        test_starvation();
        test_reset_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
